// File: rtl/fft_result_unloader_if.sv
// Purpose : bundles the unloader's control, result-memory read port and output beat stream.
// Latency : none; wiring only.
// Backpressure: o_ready is the only backpressure input; the unloader throttles s_re from it.
// Ports   : master = unloader side (drives s_addr/s_re/o_*/busy/done), slave = environment side.
//           o_mag exists only when FFT_MAG_EN is defined.
interface fft_result_unloader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] s_addr;
  logic              s_re;
  logic [DATA_W-1:0] s_data;
  logic [DATA_W-1:0] o_data;
  logic [ADDR_W-1:0] o_index;
  logic              o_valid;
  logic              o_ready;
  logic              o_last;
`ifdef FFT_MAG_EN
  logic [DATA_W/2:0] o_mag;
`endif

  modport master (
`ifdef FFT_MAG_EN
    output o_mag,
`endif
    input  start, s_data, o_ready,
    output busy, done, s_addr, s_re, o_data, o_index, o_valid, o_last
  );

  modport slave (
`ifdef FFT_MAG_EN
    input  o_mag,
`endif
    output start, s_data, o_ready,
    input  busy, done, s_addr, s_re, o_data, o_index, o_valid, o_last
  );
endinterface

// File: rtl/fft_result_unloader.sv
// Purpose : drains one frame of N_POINTS bins from the FFT result memory as an in-order beat stream.
// Latency : first o_valid RD_LAT+1 cycles after first s_re; start->done = N_POINTS+RD_LAT+2 with o_ready=1.
// Backpressure: reads are credit-limited (FIFO entries + reads in flight < FIFO_DEPTH); no bin is ever dropped.
// Ports   : clk, rst (async, active-high); io = fft_result_unloader_if.master
//           (start/busy/done control, s_addr/s_re/s_data memory port, o_* beat stream).
// Option  : FFT_MAG_EN adds o_mag = |re| + |im| carried through the FIFO with each beat.
module fft_result_unloader #(
  parameter int N_POINTS   = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_result_unloader_if.master io
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_q;

  // Capture pipeline: tags each issued read with its bin index until its data returns.
  logic [RD_LAT-1:0] pipe_vld_q;
  logic [ADDR_W-1:0] pipe_idx_q [RD_LAT];

  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_dat_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] mem_idx_q [FIFO_DEPTH];

  logic issue, push, pop, empty;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  // Every read in flight already owns a FIFO slot, so a push can never hit a full FIFO.
  assign issue = (state_q == READ) && ((count_q + inflight_q) < DEPTH_C);
  assign push  = pipe_vld_q[RD_LAT-1];
  assign pop   = !empty && io.o_ready;

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !push)      inflight_d = inflight_q + CNT_W'(1);
    else if (!issue && push) inflight_d = inflight_q - CNT_W'(1);
    count_d = count_q;
    if (push && !pop)        count_d = count_q + CNT_W'(1);
    else if (!push && pop)   count_d = count_q - CNT_W'(1);
  end

  // Control FSM; busy/done are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // done_q high means the previous frame just closed; a start in that cycle is dropped.
          if (io.start && !done_q) begin
            state_q <= READ;
            busy_q  <= 1'b1;
            addr_q  <= '0;
          end
        end
        READ: begin
          if (issue) begin
            addr_q <= addr_q + ADDR_W'(1);
            if (addr_q == LAST_IDX) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && io.o_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_idx_q[i] <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pipe_vld_q[0] <= issue;
      pipe_idx_q[0] <= addr_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_idx_q[i] <= pipe_idx_q[i-1];
      end
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Storage needs no reset: entries are only visible once pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dat_q[wr_ptr_q] <= io.s_data;
      mem_idx_q[wr_ptr_q] <= pipe_idx_q[RD_LAT-1];
    end
  end

`ifdef FFT_MAG_EN
  localparam int HALF = DATA_W / 2;
  logic [HALF:0] re_ext, im_ext, re_abs, im_abs, mag;
  logic [HALF:0] mem_mag_q [FIFO_DEPTH];

  // One extra bit so abs(-32768) = 32768 fits without saturation.
  assign re_ext = {io.s_data[DATA_W-1], io.s_data[DATA_W-1:HALF]};
  assign im_ext = {io.s_data[HALF-1], io.s_data[HALF-1:0]};
  assign re_abs = re_ext[HALF] ? ('0 - re_ext) : re_ext;
  assign im_abs = im_ext[HALF] ? ('0 - im_ext) : im_ext;
  assign mag    = re_abs + im_abs;

  always_ff @(posedge clk) begin
    if (push) mem_mag_q[wr_ptr_q] <= mag;
  end

  assign io.o_mag = empty ? '0 : mem_mag_q[rd_ptr_q];
`endif

  // Outputs are forced to zero when nothing is held so reset shows all-zero immediately.
  assign io.s_re    = issue;
  assign io.s_addr  = (state_q == READ) ? addr_q : '0;
  assign io.busy    = busy_q;
  assign io.done    = done_q;
  assign io.o_valid = !empty;
  assign io.o_data  = empty ? '0 : mem_dat_q[rd_ptr_q];
  assign io.o_index = empty ? '0 : mem_idx_q[rd_ptr_q];
  assign io.o_last  = !empty && (mem_idx_q[rd_ptr_q] == LAST_IDX);
endmodule
